// File: rtl/fc_head.sv
// Dense classifier head: one signed 24x8 MAC per cycle over a snapshot of the conv map,
// producing per-class scores and a running argmax of those scores.
module fc_head #(
    parameter int unsigned IN_H  = 12,
    parameter int unsigned IN_W  = 11,
    parameter int unsigned N_CLS = 10,
    parameter int unsigned ACC_W = 40
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [23:0]      in_buff  [IN_H][IN_W],
    input  logic signed [7:0]       w_fc     [N_CLS][IN_H][IN_W],
    input  logic signed [31:0]      b_fc     [N_CLS],
    output logic signed [ACC_W-1:0] scores   [N_CLS],
    output logic        [3:0]       class_id,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int unsigned RW = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int unsigned CW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int unsigned KW = (N_CLS > 1) ? $clog2(N_CLS) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMac  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]              state_q;
    logic                    prev_v_q;
    logic [RW-1:0]           r_q;
    logic [CW-1:0]           c_q;
    logic [KW-1:0]           k_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] best_q;
    logic [3:0]              best_idx_q;
    logic signed [23:0]      buf_q    [IN_H][IN_W];
    logic signed [ACC_W-1:0] scores_q [N_CLS];
    logic [3:0]              class_id_q;
    logic                    out_valid_q;
    logic                    busy_q;
    logic                    overrun_q;

    logic                    start;
    logic                    accept;
    logic                    first_elem;
    logic                    col_end;
    logic                    row_end;
    logic                    cls_end;
    logic                    last_cls;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] acc_sum;

    always_comb begin
        start      = in_valid & ~prev_v_q;
        accept     = start & (state_q != StMac);
        first_elem = (r_q == '0) && (c_q == '0);
        col_end    = (c_q == CW'(IN_W - 1));
        row_end    = (r_q == RW'(IN_H - 1));
        cls_end    = row_end & col_end;
        last_cls   = (k_q == KW'(N_CLS - 1));
        prod       = 32'(buf_q[r_q][c_q]) * 32'(w_fc[k_q][r_q][c_q]);
        // Bias replaces the running sum on the first element of each class.
        acc_sum    = (first_elem ? ACC_W'(b_fc[k_q]) : acc_q) + ACC_W'(prod);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            prev_v_q    <= 1'b1;
            r_q         <= '0;
            c_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            class_id_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int unsigned k = 0; k < N_CLS; k++) scores_q[k] <= '0;
            for (int unsigned r = 0; r < IN_H; r++)
                for (int unsigned c = 0; c < IN_W; c++) buf_q[r][c] <= '0;
        end else begin
            prev_v_q <= in_valid;
            if (accept) begin
                for (int unsigned r = 0; r < IN_H; r++)
                    for (int unsigned c = 0; c < IN_W; c++) buf_q[r][c] <= in_buff[r][c];
                out_valid_q <= 1'b0;
                overrun_q   <= 1'b0;
                busy_q      <= 1'b1;
                r_q         <= '0;
                c_q         <= '0;
                k_q         <= '0;
                state_q     <= StMac;
            end else begin
                case (state_q)
                    StMac: begin
                        if (start) overrun_q <= 1'b1;
                        acc_q <= acc_sum;
                        if (col_end) begin
                            c_q <= '0;
                            r_q <= row_end ? '0 : r_q + 1'b1;
                        end else begin
                            c_q <= c_q + 1'b1;
                        end
                        if (cls_end) begin
                            scores_q[k_q] <= acc_sum;
                            // Strict compare keeps the lowest index on ties.
                            if ((k_q == '0) || (acc_sum > best_q)) begin
                                best_q     <= acc_sum;
                                best_idx_q <= 4'(k_q);
                            end
                            k_q <= last_cls ? '0 : k_q + 1'b1;
                            if (last_cls) state_q <= StDone;
                        end
                    end
                    StDone: begin
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        class_id_q  <= best_idx_q;
                        state_q     <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign scores    = scores_q;
    assign class_id  = class_id_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/fc_head.md
FC_HEAD -- requirements
Module: fc_head

Interface
REQ-001 SHALL have parameter IN_H, default 12, input map rows.
REQ-002 SHALL have parameter IN_W, default 11, input map columns.
REQ-003 SHALL have parameter N_CLS, default 10, number of output classes.
REQ-004 SHALL have parameter ACC_W, default 40, accumulator and score width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, level-valid from the upstream conv stage's out_valid.
REQ-008 SHALL have port in_buff, input, signed 24 x [IN_H][IN_W], the conv stage's out_buff.
REQ-009 SHALL have port w_fc, input, signed 8 x [N_CLS][IN_H][IN_W], dense weights.
REQ-010 SHALL have port b_fc, input, signed 32 x [N_CLS], per-class bias.
REQ-011 SHALL have port scores, output, signed ACC_W x [N_CLS], class scores.
REQ-012 SHALL have port class_id, output, 4 bits, argmax index.
REQ-013 SHALL have port out_valid, output, 1, results valid.
REQ-014 SHALL have port busy, output, 1, computation in progress.
REQ-015 SHALL have port overrun, output, 1, sticky flag for a dropped start.

Function
REQ-016 SHALL register in_valid as prev_v; a start event SHALL be in_valid=1 with prev_v=0.
REQ-017 SHALL implement FSM states IDLE, MAC, DONE; DONE SHALL last exactly one cycle.
REQ-018 On a start event in IDLE or DONE at edge E0, SHALL snapshot in_buff into an internal buffer, clear out_valid, clear overrun, set busy, and enter MAC.
REQ-019 In MAC, SHALL perform one signed 24x8 multiply-accumulate per cycle, row-major (r outer, c inner), classes ascending.
REQ-020 Acc SHALL preload with sign-extended b_fc[k] at the first element of class k.
REQ-021 SHALL write scores[k] on the edge that adds the last element of class k, at E0 + (k+1)*IN_H*IN_W.
REQ-022 Width rule: 32-bit product, ACC_W accumulation with full sign extension, no saturation and no overflow, since 132 terms need at most 40 bits.
REQ-023 SHALL compute the argmax incrementally as each score is written, using strict greater-than so the lowest index wins ties.
REQ-024 After the last class, SHALL enter DONE; at E0 + N_CLS*IN_H*IN_W + 1 (1321 at defaults) it SHALL assert out_valid, deassert busy, present the final class_id, then return to IDLE.
REQ-025 out_valid, scores and class_id SHALL hold until the next accepted start.
REQ-026 A start event while in MAC SHALL be dropped, set overrun=1, and leave the computation unaffected.
REQ-027 w_fc and b_fc SHALL be read live; the upstream block holds them stable while busy=1.
REQ-028 in_buff changes after E0 SHALL NOT affect the result.
REQ-029 in_valid staying high after a start SHALL NOT re-trigger; only a new 0-to-1 transition starts a run.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE and clear scores, class_id, out_valid, busy, overrun, counters and acc to 0, regardless of state.
REQ-031 prev_v SHALL reset to 1, so in_valid held high through reset release does not start a run.
REQ-032 Reset mid-MAC SHALL discard the partial run with no output update.

Verification
REQ-033 All in_buff=1, all w_fc=1, b_fc=0, pulse in_valid -> scores[0..9]=132, class_id=0, out_valid exactly 1321 cycles after the capture edge, busy high for 1321 cycles.
REQ-034 Same as REQ-033 with w_fc[3][*][*]=2 -> scores[3]=264, other scores 132, class_id=3.
REQ-035 in_buff=24'h7FFFFF, w_fc=-128, b_fc=0 -> every score = -141733903872 with correct 40-bit sign, class_id=0.
REQ-036 REQ-033 stimulus with b_fc[7]=1, plus a second in_valid rising edge at cycle 300 -> scores[7]=133, class_id=7, overrun=1, result unchanged by the second edge.
REQ-037 Reset asserted at cycle 500 of a run -> all outputs 0 in the same cycle; a fresh start after release reproduces REQ-033 exactly.
REQ-038 Randomized in_buff, w_fc and b_fc across 20 runs -> every scores[k] and class_id match a behavioural reference, with zero mismatches.
